fifo_word_packer: RTL and testbench

Downstream consumer of the FIFO stage: drains items through the FIFO's pop/empty/dataOut interface and packs PACK consecutive items into one wide word. The word is presented on a valid/ready output handshake. The packer respects the FIFO's push-priority rule, where a pop issued in the same cycle as a push is a no-op, so no item is lost or duplicated. It sits between the FIFO and any wide-word sink.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/packer_slot_bank.sv | 30 +++
 rtl/fifo_word_packer.sv | 89 ++++++++
 tb/tb_fifo_word_packer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults, packer state encoding and word-width helper for the FIFO word packer.
// Optional feature macro used by the packer: PACKER_PARITY_EN.
package fifo_pkg;

    localparam int MSBD_DEF   = 3;
    localparam int PACK_DEF   = 4;
    localparam int MSBC_DEF   = 1;
    localparam int WORD_W_DEF = (MSBD_DEF + 1) * PACK_DEF;

    localparam logic [0:0] PK_FILL = 1'b0;
    localparam logic [0:0] PK_HOLD = 1'b1;

    function automatic int word_width(input int msbd, input int pack);
        return (msbd + 1) * pack;
    endfunction

endpackage

// File: rtl/packer_slot_bank.sv
// PACK item registers written one slot at a time; exposes all slots as one flat word.
module packer_slot_bank
    import fifo_pkg::*;
#(
    parameter int MSBD = MSBD_DEF,
    parameter int PACK = PACK_DEF,
    parameter int MSBC = MSBC_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          we,
    input  logic [MSBC:0]                 idx,
    input  logic [MSBD:0]                 data,
    output logic [word_width(MSBD, PACK)-1:0] wordOut
);

    localparam int ITEM_W = MSBD + 1;

    // Slots are only ever overwritten; a new word replaces every slot before it is presented.
    for (genvar i = 0; i < PACK; i++) begin : g_slot
        always_ff @(posedge clock) begin
            if (reset) begin
                wordOut[i*ITEM_W +: ITEM_W] <= '0;
            end else if (we && (idx == (MSBC+1)'(i))) begin
                wordOut[i*ITEM_W +: ITEM_W] <= data;
            end
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a FIFO through pop/empty/dataOut and packs PACK items into one word on a valid/ready port.
// Optional feature macro: PACKER_PARITY_EN adds the registered wordParity output.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int MSBD = MSBD_DEF,
    parameter int PACK = PACK_DEF,
    parameter int MSBC = MSBC_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [MSBD:0]                     dataIn,
    input  logic                              empty,
    input  logic                              push,
    output logic                              pop,
    output logic [word_width(MSBD, PACK)-1:0] wordOut,
    output logic                              wordValid,
    input  logic                              wordReady,
`ifdef PACKER_PARITY_EN
    output logic [MSBC:0]                     fillCount,
    output logic                              wordParity
`else
    output logic [MSBC:0]                     fillCount
`endif
);

    localparam int            ITEM_W   = MSBD + 1;
    localparam logic [MSBC:0] LAST_IDX = (MSBC+1)'(PACK - 1);

    logic [0:0] state;
    logic       accept;
    logic       last_item;

    // A pop that coincides with a FIFO push is ignored by the FIFO, so only pop & ~push consumes an item.
    assign pop       = (state == PK_FILL) && !empty && !reset;
    assign accept    = pop && !push;
    assign last_item = (fillCount == LAST_IDX);
    assign wordValid = (state == PK_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PK_FILL;
            fillCount <= '0;
        end else begin
            case (state)
                PK_FILL: begin
                    if (accept) begin
                        if (last_item) begin
                            fillCount <= '0;
                            state     <= PK_HOLD;
                        end else begin
                            fillCount <= fillCount + 1'b1;
                        end
                    end
                end
                default: begin
                    if (wordReady) begin
                        state <= PK_FILL;
                    end
                end
            endcase
        end
    end

    packer_slot_bank #(
        .MSBD (MSBD),
        .PACK (PACK),
        .MSBC (MSBC)
    ) u_slot_bank (
        .clock   (clock),
        .reset   (reset),
        .we      (accept),
        .idx     (fillCount),
        .data    (dataIn),
        .wordOut (wordOut)
    );

`ifdef PACKER_PARITY_EN
    // Lower slots already hold this word's items when the last one arrives, so fold in dataIn directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            wordParity <= 1'b0;
        end else if (accept && last_item) begin
            wordParity <= (^wordOut[ITEM_W*(PACK-1)-1:0]) ^ (^dataIn);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (MSBD=3, PACK=4) with a queue-based FIFO model driving dataIn/empty.
module tb_fifo_word_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  dataIn;
    logic        empty;
    logic        push;
    logic        pop;
    logic [15:0] wordOut;
    logic        wordValid;
    logic        wordReady;
    logic [1:0]  fillCount;
`ifdef PACKER_PARITY_EN
    logic        wordParity;
`endif

    logic [3:0]  fifo_q[$];
    logic [3:0]  push_val;
    int          checks = 0;
    int          errors = 0;
    int          pops_seen = 0;

    always #5 clock = ~clock;

    fifo_word_packer #(
        .MSBD (3),
        .PACK (4),
        .MSBC (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dataIn     (dataIn),
        .empty      (empty),
        .push       (push),
        .pop        (pop),
        .wordOut    (wordOut),
        .wordValid  (wordValid),
        .wordReady  (wordReady),
`ifdef PACKER_PARITY_EN
        .fillCount  (fillCount),
        .wordParity (wordParity)
`else
        .fillCount  (fillCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        empty  = (fifo_q.size() == 0);
        dataIn = empty ? 4'h0 : fifo_q[0];
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        fifo_q.push_back(v);
        refresh();
    endtask

    // One clock: model the FIFO's reaction to pop/push seen before the edge, then settle.
    task automatic tick();
        logic pop_s;
        logic push_s;
        pop_s  = pop;
        push_s = push;
        @(posedge clock);
        #1;
        if (pop_s && !push_s) begin
            void'(fifo_q.pop_front());
            pops_seen++;
        end
        if (push_s) fifo_q.push_back(push_val);
        refresh();
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        push_val  = 4'h0;
        wordReady = 1'b1;
        refresh();
        load(4'h7);
        tick();
        tick();
        check("rst_pop", pop, 0);
        check("rst_valid", wordValid, 0);
        check("rst_fill", fillCount, 0);
        check("rst_word", wordOut, 16'h0000);
`ifdef PACKER_PARITY_EN
        check("rst_parity", wordParity, 0);
`endif
        fifo_q.delete();
        refresh();
        reset = 1'b0;
        #1;

        // Basic packing
        pops_seen = 0;
        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        check("basic_pop0", pop, 1);
        tick(); check("basic_fill1", fillCount, 1);
        tick(); check("basic_fill2", fillCount, 2);
        tick(); check("basic_fill3", fillCount, 3);
        check("basic_notyet", wordValid, 0);
        tick();
        check("basic_valid", wordValid, 1);
        check("basic_word", wordOut, 16'h4321);
        check("basic_fill0", fillCount, 0);
        check("basic_pops", pops_seen, 4);
        check("basic_hold_pop", pop, 0);
`ifdef PACKER_PARITY_EN
        check("basic_parity", wordParity, 1);
`endif
        tick();
        check("basic_release", wordValid, 0);

        // Push collision on the second pop
        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        tick(); check("coll_fill1", fillCount, 1);
        push = 1'b1; push_val = 4'h5; #1;
        check("coll_pop_indep", pop, 1);
        tick();
        push = 1'b0; #1;
        check("coll_hold_fill", fillCount, 1);
        tick(); check("coll_fill2", fillCount, 2);
        wordReady = 1'b0;
        tick(); check("coll_fill3", fillCount, 3);
        check("coll_latency", wordValid, 0);
        tick();
        check("coll_valid", wordValid, 1);
        check("coll_word", wordOut, 16'h4321);

        // Backpressure with an item (5) waiting in the FIFO
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_pop", pop, 0);
            check("bp_valid", wordValid, 1);
            check("bp_word", wordOut, 16'h4321);
        end
        wordReady = 1'b1; #1;
        tick();
        check("bp_accepted", wordValid, 0);
        check("bp_resume_pop", pop, 1);

        // Empty stall after two items
        load(4'h6);
        tick(); check("stall_fill1", fillCount, 1);
        tick(); check("stall_fill2", fillCount, 2);
        for (int i = 0; i < 3; i++) begin
            check("stall_pop", pop, 0);
            tick();
            check("stall_fill_hold", fillCount, 2);
        end
        load(4'h7); load(4'h8);
        tick(); check("stall_fill3", fillCount, 3);
        tick();
        check("stall_valid", wordValid, 1);
        check("stall_word", wordOut, 16'h8765);
`ifdef PACKER_PARITY_EN
        check("stall_parity", wordParity, 0);
`endif
        tick();

        // Reset mid-word
        load(4'h9); load(4'hA); load(4'hB);
        tick(); tick(); tick();
        check("mid_fill3", fillCount, 3);
        reset = 1'b1; #1;
        tick();
        check("mid_rst_fill", fillCount, 0);
        check("mid_rst_valid", wordValid, 0);
        check("mid_rst_pop", pop, 0);
        reset = 1'b0; #1;
        load(4'hD); load(4'hE); load(4'hF); load(4'h1);
        tick(); tick(); tick(); tick();
        check("mid_valid", wordValid, 1);
        check("mid_word", wordOut, 16'h1FED);
        tick();

`ifdef PACKER_PARITY_EN
        // All-ones word has even parity
        load(4'hF); load(4'hF); load(4'hF); load(4'hF);
        tick(); tick(); tick(); tick();
        check("par_word", wordOut, 16'hFFFF);
        check("par_bit", wordParity, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
